pu_operand_loader: RTL
======================

# pu_operand_loader

Upstream feeder for the PU2 processing unit. It accepts a serial stream of XLEN-bit operands over a valid/ready handshake and packs every four consecutive operands into one parallel group, presented on `num1`..`num4` with its own valid/ready handshake. A short final group, marked by `in_last`, is zero-padded. The loader's outputs connect directly to PU2's `num1`..`num4` inputs.

## Interface
- `XLEN`, default 5: operand width; must match PU2.
- `CNTW`, default 8: width of the group counter.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_data` input XLEN: serial operand.
- `in_valid` input 1: `in_data` is valid.
- `in_last` input 1: the current operand is the last of the stream; qualified by `in_valid`.
- `in_ready` output 1: the loader can accept an operand this cycle.
- `num1`, `num2`, `num3`, `num4` output XLEN each: packed group. `num1` holds the first accepted operand.
- `out_valid` output 1: the group on `num1`..`num4` is valid.
- `out_last` output 1: this group ends the stream; qualified by `out_valid`.
- `out_ready` input 1: downstream PU2 takes the group.
- `group_cnt` output CNTW: number of groups handed off since reset; wraps modulo 2^CNTW.

## Operation
- **Input transfer:** occurs when `in_valid && in_ready`.
- **Output transfer:** occurs when `out_valid && out_ready`.
- **Internal state:** a 2-bit slot index `idx` (0..3), four XLEN-bit slot registers, and an FSM.
- **FILL state:**
  - `in_ready` = 1 and `out_valid` = 0.
  - Each input transfer writes `in_data` into slot `idx`, then increments `idx`.
  - If the transfer writes slot 3, or `in_last` = 1: the FSM goes to HOLD, `idx` returns to 0, and `out_last` latches `in_last`.
  - Slots not written in that group are cleared to 0 when the group closes. A short last group is therefore zero-padded, e.g. 2 operands give `num3` = `num4` = 0.
- **HOLD state:**
  - `out_valid` = 1.
  - `num1`..`num4` and `out_last` are stable until the output transfer.
  - `in_ready` = `out_ready`, a combinational pass-through that allows back-to-back streaming.
- **Leaving HOLD:**
  - On an output transfer, `group_cnt` increments and the FSM returns to FILL.
  - If an input transfer happens in the same cycle, that operand is written to slot 0 of the next group and `idx` becomes 1.
  - If that simultaneous operand has `in_last` = 1, the FSM stays in HOLD. The new group is `{d, 0, 0, 0}` with `out_last` = 1.
- **Width:** no arithmetic is performed on the data; operands pass through unmodified at XLEN bits.
- **`in_last` on slot 3:** a full group with `out_last` = 1; no extra padding group is generated.
- **`in_last` with nothing pending:** impossible by construction, since `in_last` always accompanies an accepted operand.

## Timing
- **Reset values (`rst` = 0, asynchronous):**
  - FSM = FILL, `idx` = 0, all slots = 0.
  - `num1`..`num4` = 0, `out_valid` = 0, `out_last` = 0.
  - `in_ready` = 1 once reset is released; it is 0 while `rst` is low.
  - `group_cnt` = 0.
- **Reset mid-operation:** a partially filled or held group is discarded, with no output transfer.
- **Latency:** the 4th (or last) operand is accepted at edge N; `out_valid` = 1 and the group is visible from edge N onward, i.e. in cycle N+1.
- **Throughput:** with `out_ready` held at 1 and `in_valid` held at 1, one group every 4 cycles. There are no bubbles because the handoff cycle also accepts slot 0.
- **Handshake rules:**
  - `out_valid` never drops without an output transfer.
  - `num*` are registered outputs.
  - `in_ready` depends combinationally only on the FSM state and `out_ready`.
- **Wrap-around:** `group_cnt` wraps from 2^CNTW − 1 to 0.

## Test plan
1. **Reset:** assert `rst` = 0 mid-fill after 2 operands, then release. Expect all outputs 0 and `in_ready` = 1; the next 4 operands 5, 6, 7, 8 give `num1..4` = 5, 6, 7, 8 with `group_cnt` → 1 after handoff.
2. **Streaming:** continuous `in_valid` with values 1..12 and `out_ready` = 1. Expect groups (1,2,3,4), (5,6,7,8), (9,10,11,12), each with `out_valid` high for exactly 1 cycle, 4 cycles apart; `group_cnt` = 3 at the end.
3. **Backpressure:** `out_ready` = 0 for 5 cycles while holding (1,2,3,4). Expect `in_ready` = 0 and outputs stable. Raise `out_ready` with `in_data` = 9 valid: expect handoff, and 9 becomes `num1` of the next group.
4. **Short last group:** operands 3, 31 with `in_last` on 31. Expect `num` = (3, 31, 0, 0) and `out_last` = 1.
5. **Last on handoff:** while holding (1,2,3,4), present 17 with `in_last`=1 and `out_ready`=1. Expect the next group (17, 0, 0, 0) with `out_last` = 1.
6. **Counter wrap:** with `CNTW` = 2, hand off 5 groups. Expect `group_cnt` sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/pu_operand_loader.sv
// Serial-to-parallel operand packer feeding PU2: collects four XLEN-bit operands
// per group, zero-pads a short final group, and hands it off over valid/ready.
module pu_operand_loader #(
  parameter int XLEN = 5,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_last,
  output logic            in_ready,
  output logic [XLEN-1:0] num1,
  output logic [XLEN-1:0] num2,
  output logic [XLEN-1:0] num3,
  output logic [XLEN-1:0] num4,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic [CNTW-1:0] group_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  state_t          state;
  logic [1:0]      idx;
  logic [XLEN-1:0] slot [4];
  logic            in_fire;
  logic            out_fire;

  // In HOLD, accepting depends on the group leaving this same cycle, which is
  // what lets the handoff cycle also take slot 0 of the next group.
  always_comb begin
    // NOTE: assign a default before any condition so no latch is inferred.
    in_ready = 1'b0;
    if (rst) begin
      in_ready = (state == FILL) ? 1'b1 : out_ready;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // The slot registers drive PU2 directly, so the outputs are registered.
  assign num1 = slot[0];
  assign num2 = slot[1];
  assign num3 = slot[2];
  assign num4 = slot[3];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      idx       <= 2'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      group_cnt <= '0;
      // NOTE: the four slots are plain flops visible on num1..num4, so they
      // are reset along with the control state.
      for (int i = 0; i < 4; i++) begin
        slot[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            slot[idx] <= in_data;
            if (idx == 2'd3 || in_last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_last  <= in_last;
              idx       <= 2'd0;
              // Zero-pad whatever this group did not write.
              for (int i = 0; i < 4; i++) begin
                if (i > int'(idx)) begin
                  slot[i] <= '0;
                end
              end
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        HOLD: begin
          if (out_fire) begin
            group_cnt <= group_cnt + CNT_ONE;
            if (in_fire) begin
              slot[0] <= in_data;
              if (in_last) begin
                // A one-operand final group closes immediately: stay in HOLD.
                out_last <= 1'b1;
                idx      <= 2'd0;
                for (int i = 1; i < 4; i++) begin
                  slot[i] <= '0;
                end
              end else begin
                state     <= FILL;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                idx       <= 2'd1;
              end
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              idx       <= 2'd0;
            end
          end
        end

        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          idx       <= 2'd0;
        end
      endcase
    end
  end

endmodule
